run_scheduler: RTL and testbench

- Batch controller for the random-order asynchronous network datapath.
- Accepts one batch config: run count, base seed, inhibitor list. For each run it clears the datapath, loads inhibitors one per cycle, pulses start, and waits for steady state or a round limit.
- Returns each run's final state through a valid/ready result port, then steps the seed and repeats.
- Sits between the host/command interface and the datapath's clear/start/inhibitor/seed inputs.

---
 rtl/run_scheduler_pkg.sv | 32 +++
 rtl/sched_seed_gen.sv | 28 ++
 rtl/run_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_run_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_scheduler_pkg.sv
// Shared types and constants for the run scheduler.
// The optional abort input is controlled by the RUN_SCHEDULER_ABORT_EN macro in run_scheduler.sv.
package run_scheduler_pkg;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_LOAD_INH = 3'd2,
        S_START    = 3'd3,
        S_WAIT     = 3'd4,
        S_REPORT   = 3'd5,
        S_NEXT     = 3'd6
    } sched_state_t;

    // Golden-ratio increment applied to the seed between runs
    localparam logic [63:0] SEED_STEP = 64'h9E3779B97F4A7C15;

    // Default widths of the captured result fields
    localparam int NET_W   = 16;
    localparam int RUN_W   = 8;
    localparam int ROUND_W = 10;

    // One captured run result
    typedef struct packed {
        logic [NET_W-1:0]   state;
        logic [ROUND_W-1:0] rounds;
        logic [RUN_W-1:0]   run_idx;
        logic               timeout;
    } sched_result_t;

endpackage

// File: rtl/sched_seed_gen.sv
// Per-run seed register: loads the batch base seed, steps by SEED_STEP between runs.
module sched_seed_gen
    import run_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] load_seed,
    input  logic        step,
    output logic [63:0] seed
);

    logic [63:0] seed_reg;

    // Seed register; the add wraps modulo 2^64 by construction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seed_reg <= '0;
        end else if (load) begin
            seed_reg <= load_seed;
        end else if (step) begin
            seed_reg <= seed_reg + SEED_STEP;
        end
    end

    assign seed = seed_reg;

endmodule

// File: rtl/run_scheduler.sv
// Batch controller for the asynchronous network datapath: clears, loads
// inhibitors, starts, waits for steady state or a round limit, and reports
// each run's final state. Optional abort input: define RUN_SCHEDULER_ABORT_EN.
module run_scheduler
    import run_scheduler_pkg::*;
#(
    parameter int RULES       = NET_W,
    parameter int LOG_RULES   = 4,
    parameter int MAX_INH     = 4,
    parameter int RUNS_W      = RUN_W,
    parameter int ROUND_LIMIT = 1000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [RUNS_W-1:0]              cfg_runs,
    input  logic [63:0]                    cfg_seed,
    input  logic [$clog2(MAX_INH+1)-1:0]   cfg_inh_count,
    input  logic [MAX_INH*LOG_RULES-1:0]   cfg_inh_list,
    output logic                           dp_clear,
    output logic                           dp_start,
    output logic                           dp_ld_inhibitor,
    output logic [LOG_RULES-1:0]           dp_sel_inhibitor,
    output logic [63:0]                    dp_seed,
    input  logic [RULES-1:0]               dp_network_state,
    input  logic                           dp_steady_state,
    input  logic [9:0]                     dp_round_number,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [RULES-1:0]               res_state,
    output logic [9:0]                     res_rounds,
    output logic [RUNS_W-1:0]              res_run_idx,
    output logic                           res_timeout,
    output logic                           busy,
    output logic                           batch_done
`ifdef RUN_SCHEDULER_ABORT_EN
    ,
    input  logic                           abort
`endif
);

    localparam int CNT_W = $clog2(MAX_INH+1);
    localparam int IDX_W = (MAX_INH > 1) ? $clog2(MAX_INH) : 1;

    sched_state_t                 state_reg, state_next;
    logic [RUNS_W-1:0]            runs_reg;
    logic [RUNS_W-1:0]            run_idx_reg, run_idx_next;
    logic [CNT_W-1:0]             inh_cnt_reg;
    logic [MAX_INH*LOG_RULES-1:0] inh_list_reg;
    logic [IDX_W-1:0]             inh_idx_reg, inh_idx_next;
    logic                         wait_armed_reg;
    sched_result_t                result_reg, result_next;
    logic                         batch_done_reg, batch_done_next;
    logic                         abort_pend_reg, abort_pend_next;
    logic                         abort_req;
    logic                         cfg_accept;
    logic                         seed_step;
    logic                         inh_last;
    logic [CNT_W-1:0]             cfg_inh_clamped;
    logic [LOG_RULES-1:0]         inh_arr [MAX_INH];

`ifdef RUN_SCHEDULER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Unpack the latched inhibitor list; entry 0 sits in the LSBs
    genvar gi;
    generate
        for (gi = 0; gi < MAX_INH; gi++) begin : g_inh
            assign inh_arr[gi] = inh_list_reg[gi*LOG_RULES +: LOG_RULES];
        end
    endgenerate

    // Oversized inhibitor counts are clamped to the list capacity
    assign cfg_inh_clamped = (cfg_inh_count > CNT_W'(MAX_INH)) ? CNT_W'(MAX_INH) : cfg_inh_count;
    assign inh_last        = (CNT_W'(inh_idx_reg) + CNT_W'(1)) == inh_cnt_reg;

    sched_seed_gen u_seed_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (cfg_accept),
        .load_seed (cfg_seed),
        .step      (seed_step),
        .seed      (dp_seed)
    );

    // Next-state, capture and pulse decisions
    always_comb begin
        state_next      = state_reg;
        inh_idx_next    = inh_idx_reg;
        run_idx_next    = run_idx_reg;
        result_next     = result_reg;
        batch_done_next = 1'b0;
        abort_pend_next = abort_pend_reg;
        cfg_accept      = 1'b0;
        seed_step       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                abort_pend_next = 1'b0;
                if (cfg_valid) begin
                    cfg_accept   = 1'b1;
                    run_idx_next = '0;
                    if (cfg_runs == '0) begin
                        batch_done_next = 1'b1;
                    end else begin
                        state_next = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                inh_idx_next = '0;
                state_next   = (inh_cnt_reg == '0) ? S_START : S_LOAD_INH;
            end
            S_LOAD_INH: begin
                if (inh_last) begin
                    state_next = S_START;
                end else begin
                    inh_idx_next = inh_idx_reg + IDX_W'(1);
                end
            end
            S_START: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // The steady flag may be stale in the first WAIT cycle, so only act once armed
                if (wait_armed_reg) begin
                    if (dp_steady_state) begin
                        result_next.state   = NET_W'(dp_network_state);
                        result_next.rounds  = dp_round_number;
                        result_next.run_idx = RUN_W'(run_idx_reg);
                        result_next.timeout = 1'b0;
                        state_next          = S_REPORT;
                    end else if (dp_round_number >= ROUND_W'(ROUND_LIMIT)) begin
                        result_next.state   = NET_W'(dp_network_state);
                        result_next.rounds  = dp_round_number;
                        result_next.run_idx = RUN_W'(run_idx_reg);
                        result_next.timeout = 1'b1;
                        state_next          = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                if (abort_req) begin
                    abort_pend_next = 1'b1;
                end
                if (res_ready) begin
                    if (abort_pend_reg || abort_req) begin
                        state_next      = S_IDLE;
                        batch_done_next = 1'b1;
                    end else begin
                        state_next = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                seed_step    = 1'b1;
                run_idx_next = run_idx_reg + RUNS_W'(1);
                if (run_idx_reg == runs_reg - RUNS_W'(1)) begin
                    batch_done_next = 1'b1;
                    state_next      = S_IDLE;
                end else begin
                    state_next = S_CLEAR;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // Abort before a result exists drops the run without reporting it
        if (abort_req && (state_reg inside {S_CLEAR, S_LOAD_INH, S_START, S_WAIT})) begin
            state_next      = S_IDLE;
            batch_done_next = 1'b1;
            result_next     = result_reg;
        end
    end

    // State and datapath registers; reset aborts any batch in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            runs_reg       <= '0;
            run_idx_reg    <= '0;
            inh_cnt_reg    <= '0;
            inh_list_reg   <= '0;
            inh_idx_reg    <= '0;
            wait_armed_reg <= 1'b0;
            result_reg     <= '0;
            batch_done_reg <= 1'b0;
            abort_pend_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            run_idx_reg    <= run_idx_next;
            inh_idx_reg    <= inh_idx_next;
            wait_armed_reg <= (state_reg == S_WAIT);
            result_reg     <= result_next;
            batch_done_reg <= batch_done_next;
            abort_pend_reg <= abort_pend_next;
            if (cfg_accept) begin
                runs_reg     <= cfg_runs;
                inh_cnt_reg  <= cfg_inh_clamped;
                inh_list_reg <= cfg_inh_list;
            end
        end
    end

    assign cfg_ready        = (state_reg == S_IDLE);
    assign busy             = (state_reg != S_IDLE);
    assign dp_clear         = (state_reg == S_IDLE) || (state_reg == S_CLEAR);
    assign dp_start         = (state_reg == S_START);
    assign dp_ld_inhibitor  = (state_reg == S_LOAD_INH);
    assign dp_sel_inhibitor = dp_ld_inhibitor ? inh_arr[inh_idx_reg] : '0;
    assign res_valid        = (state_reg == S_REPORT);
    assign res_state        = RULES'(result_reg.state);
    assign res_rounds       = result_reg.rounds;
    assign res_run_idx      = RUNS_W'(result_reg.run_idx);
    assign res_timeout      = result_reg.timeout;
    assign batch_done       = batch_done_reg;

endmodule

// File: tb/tb_run_scheduler.sv
// Self-checking bench for run_scheduler with a small reactive datapath model.
module tb_run_scheduler;

    localparam logic [63:0] GOLDEN = 64'h9E3779B97F4A7C15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [7:0]  cfg_runs = '0;
    logic [63:0] cfg_seed = '0;
    logic [2:0]  cfg_inh_count = '0;
    logic [15:0] cfg_inh_list = '0;
    logic        dp_clear, dp_start, dp_ld_inhibitor;
    logic [3:0]  dp_sel_inhibitor;
    logic [63:0] dp_seed;
    logic [15:0] dp_network_state;
    logic        dp_steady_state;
    logic [9:0]  dp_round_number;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_state;
    logic [9:0]  res_rounds;
    logic [7:0]  res_run_idx;
    logic        res_timeout;
    logic        busy, batch_done;
`ifdef RUN_SCHEDULER_ABORT_EN
    logic        abort = 1'b0;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Datapath model parameters for the current batch
    bit cur_steady_en = 1'b0;
    int cur_steady_at = 1;
    int cur_off       = 0;
    int cyc;
    logic [63:0] seen_seeds [4];

    typedef struct {
        int          runs;
        logic [63:0] seed;
        int          inh_count;
        logic [15:0] list;
        bit          steady_en;
        int          steady_at;
        int          off;
        int          delay;
        logic [9:0]  exp_rounds;
        bit          exp_to;
    } batch_t;

    run_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_runs         (cfg_runs),
        .cfg_seed         (cfg_seed),
        .cfg_inh_count    (cfg_inh_count),
        .cfg_inh_list     (cfg_inh_list),
        .dp_clear         (dp_clear),
        .dp_start         (dp_start),
        .dp_ld_inhibitor  (dp_ld_inhibitor),
        .dp_sel_inhibitor (dp_sel_inhibitor),
        .dp_seed          (dp_seed),
        .dp_network_state (dp_network_state),
        .dp_steady_state  (dp_steady_state),
        .dp_round_number  (dp_round_number),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_state        (res_state),
        .res_rounds       (res_rounds),
        .res_run_idx      (res_run_idx),
        .res_timeout      (res_timeout),
        .busy             (busy),
        .batch_done       (batch_done)
`ifdef RUN_SCHEDULER_ABORT_EN
        ,
        .abort            (abort)
`endif
    );

    always #5 clk = ~clk;

    // Datapath model: counts cycles since start; round = offset + elapsed cycles
    always @(posedge clk) begin
        if (!rst || dp_clear) begin
            cyc <= 0;
        end else if (dp_start) begin
            cyc <= 1;
        end else if (cyc > 0 && cyc < 2000) begin
            cyc <= cyc + 1;
        end
    end

    assign dp_round_number  = (cyc == 0) ? 10'd0 :
                              ((cur_off + cyc > 1023) ? 10'd1023 : 10'(cur_off + cyc));
    assign dp_steady_state  = cur_steady_en && (cyc > 0) && (cyc >= cur_steady_at);
    assign dp_network_state = dp_seed[15:0] ^ 16'hA5A5;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: first WAIT cycle c>=2 where steady or round>=1000; steady takes priority
    function automatic void model(input batch_t b, output logic [9:0] rounds, output bit to);
        int cs, cr, c;
        cr = (1000 - b.off > 2) ? 1000 - b.off : 2;
        cs = b.steady_en ? ((b.steady_at > 2) ? b.steady_at : 2) : 100000;
        if (cs <= cr) begin
            c  = cs;
            to = 1'b0;
        end else begin
            c  = cr;
            to = 1'b1;
        end
        rounds = 10'(b.off + c);
    endfunction

    task automatic run_batch(input batch_t b, input string tag);
        int results, cycles, done_cnt, starts, loads, clamp, extra_res;
        bit prev_clear, prev_ld, hold_ok;
        logic [63:0] seed_r;
        logic [34:0] snap;
        logic [3:0]  exp_sel;
        results = 0; cycles = 0; done_cnt = 0; starts = 0; loads = 0; extra_res = 0;
        clamp = (b.inh_count > 4) ? 4 : b.inh_count;
        cur_steady_en = b.steady_en;
        cur_steady_at = b.steady_at;
        cur_off       = b.off;
        @(negedge clk);
        check({tag, ".cfg_ready"}, cfg_ready, 1);
        cfg_valid     = 1'b1;
        cfg_runs      = 8'(b.runs);
        cfg_seed      = b.seed;
        cfg_inh_count = 3'(b.inh_count);
        cfg_inh_list  = b.list;
        @(negedge clk);
        cfg_valid  = 1'b0;
        prev_clear = 1'b1;
        prev_ld    = 1'b0;
        while (cycles < 3000) begin
            if (batch_done) done_cnt++;
            if (dp_ld_inhibitor) begin
                exp_sel = b.list[loads*4 +: 4];
                check({tag, ".sel"}, dp_sel_inhibitor, exp_sel);
                check({tag, ".ld_contig"}, prev_clear || prev_ld, 1);
                loads++;
            end
            if (dp_start) begin
                check({tag, ".ld_count"}, loads, clamp);
                check({tag, ".start_follows"}, (clamp == 0) ? prev_clear : prev_ld, 1);
                seed_r = b.seed + 64'(starts) * GOLDEN;
                check({tag, ".dp_seed"}, dp_seed, seed_r);
                if (starts < 4) seen_seeds[starts] = dp_seed;
                starts++;
                loads = 0;
            end
            prev_clear = dp_clear;
            prev_ld    = dp_ld_inhibitor;
            if (res_valid) begin
                seed_r = b.seed + 64'(results) * GOLDEN;
                check({tag, ".run_idx"}, res_run_idx, results);
                check({tag, ".state"}, res_state, seed_r[15:0] ^ 16'hA5A5);
                check({tag, ".rounds"}, res_rounds, b.exp_rounds);
                check({tag, ".timeout"}, res_timeout, b.exp_to);
                $display("%s result run=%0d state=0x%04h rounds=%0d timeout=%0d",
                         tag, res_run_idx, res_state, res_rounds, res_timeout);
                snap    = {res_state, res_rounds, res_run_idx, res_timeout};
                hold_ok = 1'b1;
                for (int i = 0; i < b.delay; i++) begin
                    @(negedge clk);
                    cycles++;
                    if (!res_valid || dp_start || dp_clear ||
                        snap != {res_state, res_rounds, res_run_idx, res_timeout}) hold_ok = 1'b0;
                end
                if (b.delay > 0) check({tag, ".hold_stable"}, hold_ok, 1);
                res_ready = 1'b1;
                @(negedge clk);
                cycles++;
                res_ready = 1'b0;
                check({tag, ".valid_drop"}, res_valid, 0);
                results++;
                continue;
            end
            if (done_cnt > 0 && !busy) break;
            @(negedge clk);
            cycles++;
        end
        repeat (3) begin
            @(negedge clk);
            if (batch_done) done_cnt++;
            if (res_valid) extra_res++;
        end
        check({tag, ".results"}, results, b.runs);
        check({tag, ".starts"}, starts, b.runs);
        check({tag, ".batch_done"}, done_cnt, 1);
        check({tag, ".extra_res"}, extra_res, 0);
        check({tag, ".idle_busy"}, busy, 0);
    endtask

    batch_t tbl [8];
    batch_t rb;

    initial begin
        int starts;
        // inputs..., expected rounds, expected timeout
        tbl[0] = '{3, 64'h1,    0, 16'h0000, 1'b1, 5, 0,   0,  10'd5,    1'b0};
        tbl[1] = '{1, 64'h22,   2, 16'h0073, 1'b1, 3, 10,  0,  10'd13,   1'b0};
        tbl[2] = '{1, 64'h333,  0, 16'h0000, 1'b0, 1, 0,   1,  10'd1000, 1'b1};
        tbl[3] = '{1, 64'h4444, 0, 16'h0000, 1'b1, 5, 995, 0,  10'd1000, 1'b0};
        tbl[4] = '{2, 64'h55,   1, 16'h000C, 1'b1, 1, 100, 20, 10'd102,  1'b0};
        tbl[5] = '{0, 64'h66,   0, 16'h0000, 1'b1, 5, 0,   0,  10'd0,    1'b0};
        tbl[6] = '{1, 64'h77,   7, 16'h4321, 1'b1, 2, 0,   0,  10'd2,    1'b0};
        tbl[7] = '{1, 64'h88,   4, 16'h590F, 1'b0, 1, 998, 2,  10'd1000, 1'b1};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst.dp_clear", dp_clear, 1);
        check("rst.busy", busy, 0);
        check("rst.cfg_ready", cfg_ready, 1);
        check("rst.dp_seed", dp_seed, 0);
        check("rst.res_valid", res_valid, 0);
        check("rst.res_state", res_state, 0);
        check("rst.batch_done", batch_done, 0);
        check("rst.dp_start", dp_start, 0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_batch(tbl[i], $sformatf("tbl%0d", i));
            if (i == 0) begin
                check("tbl0.seed1", seen_seeds[1], 64'h9E3779B97F4A7C16);
                check("tbl0.seed2", seen_seeds[2], 64'h3C6EF372FE94F82B);
            end
        end

        // Reset during WAIT of run 1 aborts the batch
        cur_steady_en = 1'b1;
        cur_steady_at = 50;
        cur_off       = 0;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_runs = 8'd3; cfg_seed = 64'h5; cfg_inh_count = 3'd0;
        res_ready = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        starts = 0;
        for (int i = 0; i < 400 && starts < 2; i++) begin
            if (dp_start) starts++;
            @(negedge clk);
        end
        check("rstmid.reached_run1", starts, 2);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid.dp_clear", dp_clear, 1);
        check("rstmid.busy", busy, 0);
        check("rstmid.res_valid", res_valid, 0);
        check("rstmid.cfg_ready", cfg_ready, 1);
        res_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_batch('{1, 64'h99, 0, 16'h0, 1'b1, 4, 0, 0, 10'd4, 1'b0}, "post_rst");

        // Randomized batches against the reference model
        for (int i = 0; i < 16; i++) begin
            rb.runs      = $urandom_range(1, 3);
            rb.seed      = {$urandom, $urandom};
            rb.inh_count = $urandom_range(0, 6);
            rb.list      = 16'($urandom);
            rb.steady_en = 1'($urandom_range(0, 1));
            rb.steady_at = $urandom_range(1, 10);
            rb.off       = rb.steady_en ? $urandom_range(0, 1000) : $urandom_range(980, 1000);
            rb.delay     = $urandom_range(0, 3);
            model(rb, rb.exp_rounds, rb.exp_to);
            run_batch(rb, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
